// File: rtl/motion_pkg.sv
// Shared types and constants for the stepper trajectory generators.
package motion_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [1:0] SIDE_XF = 2'd0;
    localparam logic [1:0] SIDE_YF = 2'd1;
    localparam logic [1:0] SIDE_XR = 2'd2;
    localparam logic [1:0] SIDE_YR = 2'd3;

    localparam int DEF_RATIO = 62;

    function automatic logic side_is_y(input logic [1:0] s);
        return (s == SIDE_YF) || (s == SIDE_YR);
    endfunction

endpackage

// File: rtl/rect_tick_gen.sv
// Step-rate divider: one-cycle tick every div_i clocks (0 and 1 act as 2), held at 0 while disabled.
module rect_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d, lim;

    always_comb lim = (div_i < DIV_W'(2)) ? DIV_W'(1) : div_i - 1'b1;

    assign tick_o = en_i && (cnt_q == lim);

    always_comb cnt_d = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rect_path_gen.sv
// Two-axis rectangular step/direction generator: traces X fwd, Y fwd, X rev, Y rev
// for a programmed number of rectangles (0 = until abort).
module rect_path_gen
    import motion_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 8,
    parameter int RATIO  = DEF_RATIO,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIV_W-1:0]  div_val,
    input  logic [LEN_W-1:0]  len_x,
    input  logic [LEN_W-1:0]  len_y,
    input  logic [LOOP_W-1:0] loops,
    input  logic              dir_x0,
    input  logic              dir_y0,
    output logic              busy,
    output logic              done,
    output logic              pul_x,
    output logic              pul_y,
    output logic              dir_x,
    output logic              dir_y,
    output logic [1:0]        side
);

    localparam int SW = LEN_W + $clog2(RATIO + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     sx_q, sx_d, sy_q, sy_d, cnt_q, cnt_d;
    logic [LOOP_W-1:0] loops_q, loops_d, lcnt_q, lcnt_d, lcnt_inc;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        side_q, side_d;
    logic              dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic              pul_x_q, pul_x_d, pul_y_q, pul_y_d;
    logic              fin_q, fin_d, abt_q, abt_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic          tick, act_y, pul_act, abort_any, run_exit, skip, skip0;
    logic [SW-1:0] s_cur, sx_ld, sy_ld;
    logic [2:0]    s1, s_nx;

    rect_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == RUN),
        .div_i  (div_q),
        .tick_o (tick)
    );

    assign sx_ld = SW'(len_x) * SW'(RATIO);
    assign sy_ld = SW'(len_y) * SW'(RATIO);
    assign skip0 = (sx_ld == '0) && (sy_ld != '0);

    assign act_y     = side_is_y(side_q);
    assign pul_act   = act_y ? pul_y_q : pul_x_q;
    assign s_cur     = act_y ? sy_q : sx_q;
    assign abort_any = abort | abt_q;
    // Finish only from pul high: pending end, or abort caught between pulses.
    assign run_exit  = fin_q | (abort_any & pul_act);

    // A zero-length next side is stepped over in the same tick; its successor is
    // on the axis that just finished, which is known to be non-zero.
    assign s1       = {1'b0, side_q} + 3'd1;
    assign skip     = (side_is_y(s1[1:0]) ? sy_q : sx_q) == '0;
    assign s_nx     = skip ? s1 + 3'd1 : s1;
    assign lcnt_inc = lcnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (run_exit) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == FINISH);
    end

    always_comb begin
        sx_d    = sx_q;    sy_d    = sy_q;    cnt_d  = cnt_q;
        loops_d = loops_q; lcnt_d  = lcnt_q;  div_d  = div_q;
        side_d  = side_q;  dir_x_d = dir_x_q; dir_y_d = dir_y_q;
        pul_x_d = pul_x_q; pul_y_d = pul_y_q; fin_d  = fin_q;
        abt_d   = abt_q;
        if (state_q == IDLE && start) begin
            sx_d    = sx_ld;
            sy_d    = sy_ld;
            loops_d = loops;
            div_d   = div_val;
            cnt_d   = '0;
            lcnt_d  = '0;
            abt_d   = 1'b0;
            fin_d   = (sx_ld == '0) && (sy_ld == '0);
            side_d  = skip0 ? SIDE_YF : SIDE_XF;
            dir_x_d = dir_x0 ^ skip0;
            dir_y_d = dir_y0;
            pul_x_d = 1'b1;
            pul_y_d = 1'b1;
        end else if (state_q == RUN && !run_exit) begin
            if (abort) abt_d = 1'b1;
            if (tick) begin
                if (pul_act) begin
                    if (act_y) pul_y_d = 1'b0;
                    else       pul_x_d = 1'b0;
                end else begin
                    pul_x_d = 1'b1;
                    pul_y_d = 1'b1;
                    if (abort_any) fin_d = 1'b1;
                    if (cnt_q + 1'b1 == s_cur) begin
                        cnt_d = '0;
                        if (act_y) dir_y_d = ~dir_y_q;
                        else       dir_x_d = ~dir_x_q;
                        if (skip) begin
                            if (side_is_y(s1[1:0])) dir_y_d = ~dir_y_q;
                            else                    dir_x_d = ~dir_x_q;
                        end
                        side_d = s_nx[1:0];
                        if (s_nx[2]) begin
                            lcnt_d = lcnt_inc;
                            if (loops_q != '0 && lcnt_inc == loops_q) fin_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        end else if (state_q == FINISH) begin
            fin_d = 1'b0;
            abt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx_q    <= '0;   sy_q    <= '0;   cnt_q  <= '0;
            loops_q <= '0;   lcnt_q  <= '0;   div_q  <= '0;
            side_q  <= SIDE_XF;
            dir_x_q <= 1'b0; dir_y_q <= 1'b0;
            pul_x_q <= 1'b1; pul_y_q <= 1'b1;
            fin_q   <= 1'b0; abt_q   <= 1'b0;
            busy_q  <= 1'b0; done_q  <= 1'b0;
        end else begin
            sx_q    <= sx_d;    sy_q    <= sy_d;    cnt_q  <= cnt_d;
            loops_q <= loops_d; lcnt_q  <= lcnt_d;  div_q  <= div_d;
            side_q  <= side_d;
            dir_x_q <= dir_x_d; dir_y_q <= dir_y_d;
            pul_x_q <= pul_x_d; pul_y_q <= pul_y_d;
            fin_q   <= fin_d;   abt_q   <= abt_d;
            busy_q  <= busy_d;  done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign pul_x = pul_x_q;
    assign pul_y = pul_y_q;
    assign dir_x = dir_x_q;
    assign dir_y = dir_y_q;
    assign side  = side_q;

endmodule
